inc_register_bank: RTL and testbench

Multi-channel, parametrised successor to the single increment register. Holds NUM_CH independent WIDTH-bit counters for per-core program counters and loop/address counters in the multicore processor. Each channel supports load, step increment and step decrement against a programmable per-channel limit, with selectable wrap or saturate behaviour and terminal-condition flags. Sits between the core control units and their address/PC muxes.

---
 rtl/inc_reg_bank_pkg.sv | 20 ++
 rtl/inc_reg_channel.sv | 147 ++++++++++++++
 rtl/inc_register_bank.sv | 52 +++++
 tb/tb_inc_register_bank.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inc_reg_bank_pkg.sv
// Shared types and constants for the multi-channel increment register bank.
// Optional decrement path is enabled by defining INC_REG_BANK_DEC_EN.
package inc_reg_bank_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2,
    OP_DEC  = 2'd3
  } op_e;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Clamp a value to an upper bound.
  function automatic logic [31:0] clamp_to(input logic [31:0] val, input logic [31:0] lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/inc_reg_channel.sv
// One counter channel: value/limit pair, step inc/dec with wrap or saturate, registered flags.
// Decrement path exists only when INC_REG_BANK_DEC_EN is defined.
module inc_reg_channel
  import inc_reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic             lim_en_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] lim_i,
  input  logic             inc_en_i,
  input  logic             dec_en_i,
  input  logic             sat_mode_i,
  output logic [WIDTH-1:0] value_o,
  output logic             at_limit_o,
  output logic             at_zero_o,
  output logic             wrap_o
);

  localparam int unsigned  XW    = WIDTH + 1;
  localparam logic [XW-1:0] StepX = XW'(STEP);
  localparam logic [XW-1:0] OneX  = XW'(1);

  op_e op;

  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             at_limit_q, at_limit_d;
  logic             at_zero_q, at_zero_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] new_limit;
  logic [WIDTH-1:0] load_src;
  logic [WIDTH-1:0] load_val;

  logic [XW-1:0] val_x, lim_x, mod_x;
  logic [XW-1:0] sum_x, inc_wrap_x;
  logic          inc_over;

  assign val_x      = {1'b0, value_q};
  assign lim_x      = {1'b0, limit_q};
  assign mod_x      = lim_x + OneX;
  assign sum_x      = val_x + StepX;
  assign inc_over   = (sum_x > lim_x);
  assign inc_wrap_x = sum_x - mod_x;

`ifdef INC_REG_BANK_DEC_EN
  logic [XW-1:0] diff_x, dec_wrap_x;
  logic          dec_under;

  assign dec_under  = (val_x < StepX);
  assign diff_x     = val_x - StepX;
  assign dec_wrap_x = val_x + mod_x - StepX;
`else
  logic unused_dec;
  assign unused_dec = dec_en_i;
`endif

  // A write clamps against the limit that will be in force after this edge.
  assign new_limit = lim_en_i ? lim_i : limit_q;
  assign load_src  = wr_en_i ? data_i : value_q;
  assign load_val  = WIDTH'(clamp_to(32'(load_src), 32'(new_limit)));

  always_comb begin
    op = OP_HOLD;
    if (wr_en_i || lim_en_i) begin
      op = OP_LOAD;
`ifdef INC_REG_BANK_DEC_EN
    end else if (inc_en_i && dec_en_i) begin
      op = OP_HOLD;
    end else if (inc_en_i) begin
      op = OP_INC;
    end else if (dec_en_i) begin
      op = OP_DEC;
`else
    end else if (inc_en_i) begin
      op = OP_INC;
`endif
    end
  end

  always_comb begin
    value_d = value_q;
    limit_d = limit_q;
    wrap_d  = 1'b0;
    case (op)
      OP_LOAD: begin
        limit_d = new_limit;
        value_d = load_val;
      end
      OP_INC: begin
        if (!inc_over) begin
          value_d = sum_x[WIDTH-1:0];
        end else if (sat_mode_i == MODE_SAT) begin
          value_d = limit_q;
        end else begin
          value_d = inc_wrap_x[WIDTH-1:0];
          wrap_d  = 1'b1;
        end
      end
`ifdef INC_REG_BANK_DEC_EN
      OP_DEC: begin
        if (!dec_under) begin
          value_d = diff_x[WIDTH-1:0];
        end else if (sat_mode_i == MODE_SAT) begin
          value_d = '0;
        end else begin
          value_d = dec_wrap_x[WIDTH-1:0];
          wrap_d  = 1'b1;
        end
      end
`endif
      default: begin
        value_d = value_q;
      end
    endcase
    // Flags come from next-state so they always match the registered value.
    at_limit_d = (value_d == limit_d);
    at_zero_d  = (value_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q    <= '0;
      limit_q    <= '1;
      at_limit_q <= 1'b0;
      at_zero_q  <= 1'b1;
      wrap_q     <= 1'b0;
    end else begin
      value_q    <= value_d;
      limit_q    <= limit_d;
      at_limit_q <= at_limit_d;
      at_zero_q  <= at_zero_d;
      wrap_q     <= wrap_d;
    end
  end

  assign value_o    = value_q;
  assign at_limit_o = at_limit_q;
  assign at_zero_o  = at_zero_q;
  assign wrap_o     = wrap_q;

endmodule

// File: rtl/inc_register_bank.sv
// NUM_CH independent limit-bounded step counters with a shared write port.
// Decrement support is compiled in only when INC_REG_BANK_DEC_EN is defined.
module inc_register_bank
  import inc_reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned STEP   = 1,
  localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wrEn,
  input  logic                    limEn,
  input  logic [CH_W-1:0]         wrSel,
  input  logic [WIDTH-1:0]        dataIn,
  input  logic [WIDTH-1:0]        limIn,
  input  logic [NUM_CH-1:0]       incEn,
  input  logic [NUM_CH-1:0]       decEn,
  input  logic                    satMode,
  output logic [NUM_CH*WIDTH-1:0] dataOut,
  output logic [NUM_CH-1:0]       atLimit,
  output logic [NUM_CH-1:0]       atZero,
  output logic [NUM_CH-1:0]       wrapPulse
);

  logic [NUM_CH-1:0] sel_hit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign sel_hit[i] = (wrSel == CH_W'(i));

    inc_reg_channel #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
    ) u_ch (
      .clk_i      (clk),
      .rst_i      (rst),
      .wr_en_i    (wrEn && sel_hit[i]),
      .lim_en_i   (limEn && sel_hit[i]),
      .data_i     (dataIn),
      .lim_i      (limIn),
      .inc_en_i   (incEn[i]),
      .dec_en_i   (decEn[i]),
      .sat_mode_i (satMode),
      .value_o    (dataOut[i*WIDTH +: WIDTH]),
      .at_limit_o (atLimit[i]),
      .at_zero_o  (atZero[i]),
      .wrap_o     (wrapPulse[i])
    );
  end

endmodule

// File: tb/tb_inc_register_bank.sv
// Scoreboard bench for inc_register_bank: STEP=1 and STEP=3 instances share stimulus.
module tb_inc_register_bank;

  localparam int unsigned W    = 12;
  localparam int unsigned N    = 4;
  localparam int unsigned CW   = 2;
  localparam int          MaxV = 4095;

  typedef struct packed {
    logic [N*W-1:0] d;
    logic [N-1:0]   lim;
    logic [N-1:0]   zero;
    logic [N-1:0]   wrap;
  } obs_t;

  obs_t exp0_q[$];
  obs_t exp1_q[$];

  logic          clk = 1'b0;
  logic          rst, wr_en, lim_en, sat_mode;
  logic [CW-1:0] wr_sel;
  logic [W-1:0]  data_in, lim_in;
  logic [N-1:0]  inc_en, dec_en;

  logic [N*W-1:0] d1, d3;
  logic [N-1:0]   lim1, zero1, wrap1, lim3, zero3, wrap3;

  int n_checks = 0;
  int n_fail   = 0;
  int mval[2][N];
  int mlim[2][N];
  int step_of[2];

  always #5 clk = ~clk;

  inc_register_bank #(.WIDTH(W), .NUM_CH(N), .STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .wrEn(wr_en), .limEn(lim_en), .wrSel(wr_sel),
    .dataIn(data_in), .limIn(lim_in), .incEn(inc_en), .decEn(dec_en),
    .satMode(sat_mode), .dataOut(d1), .atLimit(lim1), .atZero(zero1), .wrapPulse(wrap1)
  );

  inc_register_bank #(.WIDTH(W), .NUM_CH(N), .STEP(3)) u_dut3 (
    .clk(clk), .rst(rst), .wrEn(wr_en), .limEn(lim_en), .wrSel(wr_sel),
    .dataIn(data_in), .limIn(lim_in), .incEn(inc_en), .decEn(dec_en),
    .satMode(sat_mode), .dataOut(d3), .atLimit(lim3), .atZero(zero3), .wrapPulse(wrap3)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Reference behaviour for the edge about to happen, one entry per instance.
  task automatic model_edge();
    obs_t o[2];
    int   v, l, s;
    bit   w, do_inc;
`ifdef INC_REG_BANK_DEC_EN
    bit   do_dec;
`endif
    for (int k = 0; k < 2; k++) begin
      o[k] = '0;
      for (int c = 0; c < int'(N); c++) begin
        v = mval[k][c];
        l = mlim[k][c];
        s = step_of[k];
        w = 1'b0;
        if (rst) begin
          v = 0;
          l = MaxV;
        end else if ((wr_en || lim_en) && int'(wr_sel) == c) begin
          if (lim_en) l = int'(lim_in);
          if (wr_en) v = int'(data_in);
          if (v > l) v = l;
        end else begin
`ifdef INC_REG_BANK_DEC_EN
          do_inc = inc_en[c] && !dec_en[c];
          do_dec = dec_en[c] && !inc_en[c];
`else
          do_inc = inc_en[c];
`endif
          if (do_inc) begin
            if (v + s <= l) v = v + s;
            else if (sat_mode) v = l;
            else begin
              v = v + s - (l + 1);
              w = 1'b1;
            end
          end
`ifdef INC_REG_BANK_DEC_EN
          else if (do_dec) begin
            if (v >= s) v = v - s;
            else if (sat_mode) v = 0;
            else begin
              v = v + (l + 1) - s;
              w = 1'b1;
            end
          end
`endif
        end
        mval[k][c]          = v;
        mlim[k][c]          = l;
        o[k].d[c*W +: W]    = W'(v);
        o[k].lim[c]         = (v == l);
        o[k].zero[c]        = (v == 0);
        o[k].wrap[c]        = w;
      end
    end
    exp0_q.push_back(o[0]);
    exp1_q.push_back(o[1]);
  endtask

  task automatic step(input string tag);
    obs_t e0, e1;
    model_edge();
    @(posedge clk);
    #1;
    e0 = exp0_q.pop_front();
    e1 = exp1_q.pop_front();
    check_eq({tag, ".s1.data"}, 64'(d1),    64'(e0.d));
    check_eq({tag, ".s1.lim"},  64'(lim1),  64'(e0.lim));
    check_eq({tag, ".s1.zero"}, 64'(zero1), 64'(e0.zero));
    check_eq({tag, ".s1.wrap"}, 64'(wrap1), 64'(e0.wrap));
    check_eq({tag, ".s3.data"}, 64'(d3),    64'(e1.d));
    check_eq({tag, ".s3.lim"},  64'(lim3),  64'(e1.lim));
    check_eq({tag, ".s3.zero"}, 64'(zero3), 64'(e1.zero));
    check_eq({tag, ".s3.wrap"}, 64'(wrap3), 64'(e1.wrap));
    rst    = 1'b0;
    wr_en  = 1'b0;
    lim_en = 1'b0;
    inc_en = '0;
    dec_en = '0;
  endtask

  task automatic write_ch(input int ch, input bit do_wr, input int val, input bit do_lim,
                          input int lim);
    wr_sel  = CW'(ch);
    wr_en   = do_wr;
    lim_en  = do_lim;
    data_in = W'(val);
    lim_in  = W'(lim);
    step("write");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    step_of[0] = 1;
    step_of[1] = 3;
    rst = 1'b0; wr_en = 1'b0; lim_en = 1'b0; sat_mode = 1'b0;
    wr_sel = '0; data_in = '0; lim_in = '0; inc_en = '0; dec_en = '0;

    rst = 1'b1;
    step("reset");
    check_eq("rst_data",  64'(d1),    64'd0);
    check_eq("rst_zero",  64'(zero1), 64'hf);
    check_eq("rst_lim",   64'(lim1),  64'd0);
    check_eq("rst_wrap",  64'(wrap1), 64'd0);

    // Default limit is full scale: 4095 loads unclamped and wraps to 0.
    write_ch(0, 1, MaxV, 0, 0);
    check_eq("ld_max", 64'(d1[11:0]), 64'd4095);
    inc_en = 4'b0001;
    step("wrap_max");
    check_eq("wrap_max_val",   64'(d1[11:0]), 64'd0);
    check_eq("wrap_max_pulse", 64'(wrap1[0]), 64'd1);
    check_eq("wrap_max_s3",    64'(d3[11:0]), 64'd2);

    write_ch(2, 1, 23, 0, 0);
    for (int i = 0; i < 3; i++) begin
      inc_en = 4'b0100;
      step("inc_ch2");
    end
    check_eq("ch2_26",      64'(d1[35:24]),           64'd26);
    check_eq("others_zero", 64'({d1[47:36], d1[23:0]}), 64'd0);

    // Ch1 limit 5: wrap then saturate.
    sat_mode = 1'b0;
    write_ch(1, 1, 4, 1, 5);
    inc_en = 4'b0010; step("ch1_inc_a");
    check_eq("ch1_at5",  64'(d1[23:12]), 64'd5);
    check_eq("ch1_atl",  64'(lim1[1]),   64'd1);
    inc_en = 4'b0010; step("ch1_inc_b");
    check_eq("ch1_wrap0", 64'(d1[23:12]), 64'd0);
    check_eq("ch1_pulse", 64'(wrap1[1]),  64'd1);
    write_ch(1, 1, 4, 0, 0);
    sat_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inc_en = 4'b0010;
      step("ch1_sat");
    end
    check_eq("ch1_sat5",    64'(d1[23:12]), 64'd5);
    check_eq("ch1_sat_np",  64'(wrap1[1]),  64'd0);

    // Consecutive wraps on the STEP=3 instance with modulus 3.
    sat_mode = 1'b0;
    write_ch(1, 1, 0, 1, 2);
    inc_en = 4'b0010; step("consec_a");
    check_eq("consec_a_pulse", 64'(wrap3[1]), 64'd1);
    inc_en = 4'b0010; step("consec_b");
    check_eq("consec_b_pulse", 64'(wrap3[1]), 64'd1);

    // STEP=3 with limit 10.
    write_ch(3, 1, 9, 1, 10);
    inc_en = 4'b1000; step("s3_inc_wrap");
    check_eq("s3_inc_wrap", 64'(d3[47:36]), 64'd1);
    write_ch(3, 1, 9, 0, 0);
    sat_mode = 1'b1;
    inc_en = 4'b1000; step("s3_inc_sat");
    check_eq("s3_inc_sat", 64'(d3[47:36]), 64'd10);
    sat_mode = 1'b0;
    write_ch(3, 1, 1, 0, 0);
    dec_en = 4'b1000; step("s3_dec_wrap");
`ifdef INC_REG_BANK_DEC_EN
    check_eq("s3_dec_wrap", 64'(d3[47:36]), 64'd9);
`else
    check_eq("s3_dec_ign",  64'(d3[47:36]), 64'd1);
`endif
    write_ch(3, 1, 1, 0, 0);
    sat_mode = 1'b1;
    dec_en = 4'b1000; step("s3_dec_sat");
`ifdef INC_REG_BANK_DEC_EN
    check_eq("s3_dec_sat", 64'(d3[47:36]), 64'd0);
`else
    check_eq("s3_dec_ign2", 64'(d3[47:36]), 64'd1);
`endif

    // Simultaneous requests.
    sat_mode = 1'b0;
    wr_sel = 2'd0; wr_en = 1'b1; data_in = 12'd7; inc_en = 4'b0001;
    step("wr_beats_inc");
    check_eq("wr_beats_inc", 64'(d1[11:0]), 64'd7);
    inc_en = 4'b1000; dec_en = 4'b1000;
    step("inc_dec_ch3");
    write_ch(1, 0, 0, 1, 100);
    write_ch(1, 1, 300, 0, 0);
    check_eq("ld_clamp", 64'(d1[23:12]), 64'd100);
    write_ch(1, 1, 80, 0, 0);
    write_ch(1, 0, 0, 1, 50);
    check_eq("lim_clamp", 64'(d1[23:12]), 64'd50);

    // Random mix, limits kept >= 2 so STEP=3 stays within its supported range.
    for (int i = 0; i < 40; i++) begin
      sat_mode = 1'($urandom_range(0, 1));
      inc_en   = N'($urandom);
      dec_en   = N'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        wr_en   = 1'($urandom_range(0, 1));
        lim_en  = 1'($urandom_range(0, 1));
        wr_sel  = CW'($urandom_range(0, 3));
        data_in = W'($urandom_range(0, MaxV));
        lim_in  = W'($urandom_range(2, MaxV));
      end
      step("rand");
    end

    // Reset mid-run overrides all requests.
    for (int i = 0; i < 5; i++) begin
      inc_en = 4'hf;
      step("run");
    end
    rst = 1'b1; inc_en = 4'hf; wr_en = 1'b1; data_in = 12'd9;
    step("mid_reset");
    check_eq("mid_rst_data", 64'(d1), 64'd0);
    check_eq("mid_rst_zero", 64'(zero1), 64'hf);
    for (int c = 0; c < int'(N); c++) write_ch(c, 1, MaxV, 0, 0);
    check_eq("lim_restored", 64'(d1), 64'hfff_fff_fff_fff);

    dec_en = 4'b0001;
    step("dec_alone");
`ifdef INC_REG_BANK_DEC_EN
    check_eq("dec_alone", 64'(d1[11:0]), 64'd4094);
`else
    check_eq("dec_ignored", 64'(d1[11:0]), 64'd4095);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
